// File: rtl/nadder_ctrl_pkg.sv
// rtl/nadder_ctrl_pkg.sv - shared FSM state type and constant helpers for SC adder-tree controllers
package nadder_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_delay_line.sv
// rtl/sc_delay_line.sv - parameterised-depth 1-bit shift register with synchronous clear
module sc_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic clr_i,
  input  logic bit_i,
  output logic tap_o
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= bit_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign tap_o = sr_q[DEPTH-1];

endmodule

// File: rtl/nadder_stream_ctrl.sv
// rtl/nadder_stream_ctrl.sv - run controller for a pipelined N-input Alaghi adder tree
// Optional abort input enabled by NADDER_STREAM_CTRL_ABORT_EN.
module nadder_stream_ctrl
  import nadder_ctrl_pkg::*;
#(
  parameter int N     = 16,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             tree_out,
`ifdef NADDER_STREAM_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             tree_rst,
  output logic             tree_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);

  localparam int LAT = clog2(N);
  localparam int DRW = clog2(LAT) + 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic             tap;
  logic             abort_act;
  logic             line_clr;

`ifdef NADDER_STREAM_CTRL_ABORT_EN
  assign abort_act = abort && ((state_q == ST_CLEAR) || (state_q == ST_STREAM) ||
                               (state_q == ST_DRAIN));
`else
  assign abort_act = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    drain_d  = drain_q;
    count_d  = count_q;
    if (tap) begin
      count_d = count_q + {{(LEN_W-1){1'b0}}, tree_out};
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CLEAR;
          remain_d = len;
          count_d  = '0;
        end
      end
      ST_CLEAR: begin
        drain_d = '0;
        state_d = (remain_q != '0) ? ST_STREAM : ST_DONE;
      end
      ST_STREAM: begin
        remain_d = remain_q - 1'b1;
        if (remain_q == LEN_W'(1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRW'(LAT - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      count_q  <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      count_q  <= count_d;
      drain_q  <= drain_d;
    end
  end

  // Leftover valid tags after an abort must not leak into the next run's count.
  assign line_clr = rst | abort_act;

  sc_delay_line #(
    .DEPTH(LAT)
  ) u_valid_line (
    .clk  (clk),
    .clr_i(line_clr),
    .bit_i(tree_en),
    .tap_o(tap)
  );

  assign tree_rst = (state_q == ST_CLEAR);
  assign tree_en  = (state_q == ST_STREAM);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign count    = count_q;

endmodule

// File: tb/tb_nadder_stream_ctrl.sv
// tb/tb_nadder_stream_ctrl.sv - directed self-checking bench for nadder_stream_ctrl
module tb_nadder_stream_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] len;
  logic       tree_out;
`ifdef NADDER_STREAM_CTRL_ABORT_EN
  logic       abort;
`endif
  logic       tree_rst;
  logic       tree_en;
  logic       busy;
  logic       done;
  logic [9:0] count;

  int n_cmp;
  int n_fail;

  nadder_stream_ctrl #(
    .N(16),
    .LEN_W(10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .tree_out(tree_out),
`ifdef NADDER_STREAM_CTRL_ABORT_EN
    .abort   (abort),
`endif
    .tree_rst(tree_rst),
    .tree_en (tree_en),
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int mode;
    int exp_count;
    int exp_done;
  } vec_t;

  task automatic chk(input string name, input string what, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, what, act, exp);
    end
  endtask

  function automatic logic tout(input int mode, input int c);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return (c < 6 || c > 105) ? 1'b1 : (((c - 6) % 2) == 0);
      3: return ((c % 3) == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Entered just after an edge; that cycle is cycle 0 of the run. Returns in cycle done+1.
  task automatic run_case(input string name, input int L, input int mode, input int s1,
                          input int s2, input int rc, input int ac, input int exp_count,
                          input int exp_done, input int budget);
    int rst_cnt, rst_first, en_cnt, en_first, en_last, done_cnt, done_cyc;
    int cnt_at_done;
    bit busy_ok, zero_ok;
    rst_cnt = 0; rst_first = -1; en_cnt = 0; en_first = -1; en_last = -1;
    done_cnt = 0; done_cyc = -1; cnt_at_done = -1; busy_ok = 1'b1; zero_ok = 1'b1;
    chk(name, "idle_at_start", int'(busy), 0);
    start = 1'b1;
    len = 10'(L);
    tree_out = tout(mode, 0);
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      start = (c == s1) || (c == s2);
      rst = (c == rc);
`ifdef NADDER_STREAM_CTRL_ABORT_EN
      abort = (c == ac);
`endif
      len = 10'(~L);
      tree_out = tout(mode, c);
      if (tree_rst) begin
        rst_cnt++;
        if (rst_first < 0) rst_first = c;
      end
      if (tree_en) begin
        en_cnt++;
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          cnt_at_done = int'(count);
        end
      end
      if (!(done_cnt > 0 && c > done_cyc)) busy_ok &= busy;
      if ((rc >= 0 && c > rc) || (ac >= 0 && c > ac)) begin
        if (tree_rst || tree_en || busy || done) zero_ok = 1'b0;
        if (rc >= 0 && count != 10'd0) zero_ok = 1'b0;
      end
      if (exp_done >= 0 && done_cnt > 0 && c == done_cyc + 1) begin
        chk(name, "busy_after_done", int'(busy), 0);
        chk(name, "done_width", int'(done), 0);
        chk(name, "count_hold", int'(count), cnt_at_done);
        break;
      end
    end
    start = 1'b0;
    rst = 1'b0;
`ifdef NADDER_STREAM_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    if (exp_done >= 0) begin
      chk(name, "done_pulses", done_cnt, 1);
      chk(name, "done_cycle", done_cyc, exp_done);
      chk(name, "count", cnt_at_done, exp_count);
      chk(name, "tree_rst_cycles", rst_cnt, 1);
      chk(name, "tree_rst_first", rst_first, 1);
      chk(name, "tree_en_cycles", en_cnt, L);
      chk(name, "busy_window", int'(busy_ok), 1);
      if (L > 0) begin
        chk(name, "tree_en_first", en_first, 2);
        chk(name, "tree_en_last", en_last, L + 1);
      end
    end else begin
      chk(name, "no_done", done_cnt, 0);
      chk(name, "outputs_idle", int'(zero_ok), 1);
      chk(name, "count_final", int'(count), exp_count);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8, 1, 8, 14};
    vecs[1] = '{100, 2, 50, 106};
    vecs[2] = '{0, 1, 0, 2};
    vecs[3] = '{1, 1, 1, 7};
    vecs[4] = '{5, 0, 0, 11};
    vecs[5] = '{20, 3, 7, 26};
    vecs[6] = '{1023, 1, 1023, 1029};
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    len = 10'd0;
    tree_out = 1'b0;
`ifdef NADDER_STREAM_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "tree_rst", int'(tree_rst), 0);
    chk("reset", "tree_en", int'(tree_en), 0);
    chk("reset", "busy", int'(busy), 0);
    chk("reset", "done", int'(done), 0);
    chk("reset", "count", int'(count), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_case($sformatf("vec%0d", i), vecs[i].len, vecs[i].mode, -1, -1, -1, -1,
               vecs[i].exp_count, vecs[i].exp_done, vecs[i].exp_done + 4);
    end

    run_case("restart_ignored", 8, 1, 3, 9, -1, -1, 8, 14, 20);
    run_case("back_to_back", 3, 1, -1, -1, -1, -1, 3, 9, 14);

    run_case("rst_mid_run", 8, 1, -1, -1, 5, -1, 0, -1, 20);
    run_case("after_rst", 4, 1, -1, -1, -1, -1, 4, 10, 14);

`ifdef NADDER_STREAM_CTRL_ABORT_EN
    run_case("abort_mid_run", 8, 1, -1, -1, -1, 4, 0, -1, 20);
    run_case("after_abort", 6, 1, -1, -1, -1, -1, 6, 12, 16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nadder_stream_ctrl.md
# nadder_stream_ctrl

- Run controller for a pipelined N-input Alaghi adder tree.
- On `start`, clears the tree's internal adder state and enables the upstream stochastic number generators for `len` stream cycles.
- Waits out the tree's pipeline latency, then counts the ones in the tree output bitstream.
- Reports the binary count with a one-cycle `done` pulse; the scaled sum is count/len × N.

## Interface
Parameters:
- `N`, 16: tree input count, power of two, ≥ 2.
- `LEN_W`, 10: width of stream length and result count.
- `LAT`, clog2(N) (derived localparam, not overridable): tree pipeline depth in cycles.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `len`  in  LEN_W  stream length in bits; captured when `start` is accepted.
- `tree_out`  in  1  output bit of the adder tree.
- `tree_rst`  out  1  clears tree adder state; high for exactly one cycle per run.
- `tree_en`  out  1  SNG/tree stream enable; high for exactly `len` cycles per run.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `count` is final in that cycle.
- `count`  out  LEN_W  number of ones observed on `tree_out` across the run's valid window.

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
  - IDLE → CLEAR on `start`. Captures `len` into `remain`, zeroes `count`.
  - CLEAR (1 cycle): `tree_rst`=1. Moves to STREAM if `remain`≠0, else to DONE.
  - STREAM: `tree_en`=1, `remain` decrements each cycle. Goes to DRAIN after the cycle where `remain`==1.
  - DRAIN: `tree_en`=0 for exactly LAT cycles, tracked by a drain counter. Then goes to DONE.
  - DONE (1 cycle): `done`=1. Returns to IDLE.
- Valid tagging:
  - A LAT-deep shift register is fed `tree_en`.
  - When its tap is 1, `count` ← `count` + `tree_out`.
  - Only bits produced from stream-enabled input cycles are counted.
- Arithmetic: `count` ≤ `len` ≤ 2^LEN_W−1, so no overflow is possible and no saturation logic is needed.
- `count` holds its value from DONE until the next accepted `start`.
- `start` while `busy` is ignored; nothing is queued.
- `len` changes after acceptance have no effect.
- `len`=0: sequence is CLEAR → DONE with `count`=0; `tree_en` is never asserted.

## Timing
- Reset values:
  - state=IDLE.
  - `tree_rst`, `tree_en`, `busy`, `done` = 0.
  - `count`, `remain`, drain counter and delay line = 0.
- `rst` asserted in any state returns every output to its reset value on the next edge. The run is discarded with no `done`.
- Cycle numbering: `start` sampled at edge 0. Then:
  - `tree_rst` in cycle 1.
  - `tree_en` in cycles 2 .. len+1.
  - Last counted `tree_out` sample in cycle len+1+LAT.
  - `done` in cycle len+2+LAT.
- Total run latency is len+2+LAT cycles; for `len`=0 it is 2 cycles.
- `busy` is high in cycles 1 .. done cycle inclusive. A new `start` can be accepted in the cycle after `done`.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.

## Configuration
- Macro: `NADDER_STREAM_CTRL_ABORT_EN`.
- Defined:
  - Adds port `abort` (in, 1).
  - `abort` high in CLEAR, STREAM or DRAIN forces IDLE on the next edge, with `tree_en`=0, no `done`, and `count` frozen at its partial value.
  - `abort` is ignored in IDLE and DONE.
  - `abort` has priority over state transitions; `rst` has priority over `abort`.
- Undefined: the `abort` port does not exist and runs always complete.

## Structure
- Shared package `nadder_ctrl_pkg` holds:
  - The FSM state enum.
  - The clog2 constant function used to derive LAT.
- Sub-module `sc_delay_line`: parameterised-depth 1-bit shift register with synchronous clear, used for valid tagging. Reusable by other SC pipeline controllers.

## Test plan
- N=16 (LAT=4), `len`=8, `tree_out` tied 1 → `tree_rst` in cycle 1, `tree_en` in cycles 2–9, `done` in cycle 14, `count`=8.
- `len`=100, `tree_out` alternating 1/0 starting at cycle 6 → `count`=50. `tree_out` held 1 outside cycles 6–105 must not change the count.
- `len`=0 → `done` in cycle 2, `count`=0, `tree_en` never high.
- `start` re-pulsed at cycles 3 and 9 of a `len`=8 run → ignored, single `done` at cycle 14. A `start` in cycle 15 begins a new run.
- `rst` pulsed in cycle 5 of a `len`=8 run → all outputs 0 from cycle 6, no `done`. A subsequent run with `len`=4 and `tree_out`=1 gives `count`=4.
- With `NADDER_STREAM_CTRL_ABORT_EN`, `abort` in cycle 4 (`len`=8, `tree_out`=1) → IDLE from cycle 5, no `done`, `busy`=0 from cycle 5.
